// File: rtl/led_ctrl.sv
// led_ctrl: memory-mapped LED bank with data, blink mask, blink divider and
// optional PWM brightness (enabled by defining LED_PWM_EN).
module led_ctrl #(
   parameter int          LED_W     = 16,
   parameter logic [31:0] BASE_ADDR = 32'hFFFF_F060,
   parameter int          CNT_W     = 24,
   parameter int          PWM_W     = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      addr,
   input  logic             we,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   output logic [LED_W-1:0] led
);
   logic             sel, wr, phase, pwm_on, unused;
   logic [1:0]       idx;
   logic [LED_W-1:0] data, mask, vis;
   logic [CNT_W-1:0] div, bcnt;
   logic [PWM_W-1:0] duty_rd;

   assign sel    = addr[31:4] == BASE_ADDR[31:4];
   assign idx    = addr[3:2];
   assign wr     = we && sel;
   assign unused = &{1'b0, addr[1:0], wdata};

   // register bank: indexed write, truncated to each register's width
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         data <= '0;
         mask <= '0;
         div  <= '0;
      end else if (wr) begin
         if (idx == 2'd0) data <= wdata[LED_W-1:0];
         if (idx == 2'd1) mask <= wdata[LED_W-1:0];
         if (idx == 2'd2) div  <= wdata[CNT_W-1:0];
      end

   // blink engine: a DIV write restarts the period in the lit phase
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if ((wr && idx == 2'd2) || div == '0) begin
         bcnt  <= '0;
         phase <= 1'b1;
      end else if (bcnt == div - CNT_W'(1)) begin
         bcnt  <= '0;
         phase <= ~phase;
      end else
         bcnt  <= bcnt + CNT_W'(1);

`ifdef LED_PWM_EN
   logic [PWM_W-1:0] duty, pcnt;

   // brightness register and free-running PWM counter
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         duty <= '1;
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + PWM_W'(1);
         if (wr && idx == 2'd3) duty <= wdata[PWM_W-1:0];
      end

   assign pwm_on  = (&duty) | (pcnt < duty);
   assign duty_rd = duty;
`else
   assign pwm_on  = 1'b1;
   assign duty_rd = '0;
`endif

   // readback mux, zero outside our window
   always_comb
      rdata = !sel        ? 32'd0 :
              idx == 2'd0 ? 32'(data) :
              idx == 2'd1 ? 32'(mask) :
              idx == 2'd2 ? 32'(div) : 32'(duty_rd);

   assign vis = data & ~(mask & {LED_W{~phase}}) & {LED_W{pwm_on}};

   // registered LED drive
   always_ff @(posedge clk or negedge rst)
      if (!rst) led <= '0;
      else      led <= vis;
endmodule

// File: tb/tb_led_ctrl.sv
// tb_led_ctrl: directed scoreboard bench for led_ctrl
module tb_led_ctrl;
   localparam logic [31:0] BASE = 32'hFFFF_F060;

   typedef struct {
      int          cyc;
      bit          is_rd;
      logic [31:0] exp;
      string       name;
   } chk_t;

   logic        clk = 1'b0, rst = 1'b0, we = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0, rdata;
   logic [15:0] led;
   int          cyc = 0, n_run = 0, n_fail = 0;
   chk_t        q[$];

   led_ctrl dut (.clk(clk), .rst(rst), .addr(addr), .we(we), .wdata(wdata), .rdata(rdata), .led(led));

   always #5 clk = ~clk;

   // cycle number of the most recent rising edge
   always @(posedge clk) cyc++;

   // monitor: compare every expectation due at this cycle, away from the edge
   always @(negedge clk) begin
      logic [31:0] act;
      for (int i = q.size() - 1; i >= 0; i--)
         if (q[i].cyc <= cyc) begin
            act = q[i].is_rd ? rdata : {16'h0, led};
            n_run++;
            if (q[i].cyc < cyc) begin
               n_fail++;
               $display("FAIL %s: check for cycle %0d missed (now %0d)", q[i].name, q[i].cyc, cyc);
            end else if (act !== q[i].exp) begin
               n_fail++;
               $display("FAIL %s @cyc %0d: got %h expected %h", q[i].name, cyc, act, q[i].exp);
            end
            q.delete(i);
         end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input int c, input bit is_rd, input logic [31:0] e, input string n);
      chk_t x;
      x.cyc = c; x.is_rd = is_rd; x.exp = e; x.name = n;
      q.push_back(x);
   endtask

   task automatic led_at(input int c, input logic [31:0] e, input string n);
      expect_at(c, 1'b0, e, n);
   endtask

   task automatic wr_abs(input logic [31:0] a, input logic [31:0] d);
      addr = a; wdata = d; we = 1'b1;
      tick();
      we = 1'b0;
   endtask

   task automatic wr(input logic [3:0] off, input logic [31:0] d);
      wr_abs(BASE + 32'(off), d);
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
      addr = a; we = 1'b0;
      expect_at(cyc, 1'b1, e, n);
      tick();
   endtask

   task automatic wait_to(input int c);
      while (cyc < c) tick();
   endtask

`ifdef LED_PWM_EN
   task automatic pwm_window(input int e, input string n);
      int hits = 0;
      for (int k = 0; k < 16; k++) begin
         tick();
         hits += int'(led[0]);
      end
      n_run++;
      if (hits != e) begin
         n_fail++;
         $display("FAIL %s: led[0] high %0d of 16 cycles expected %0d", n, hits, e);
      end
   endtask
`endif

   initial begin
      int e, a, t;
      // reset state with the clock running
      repeat (3) tick();
      led_at(cyc, 32'h0, "rst_led");
      rd(BASE,      32'h0, "rst_data");
      rd(BASE + 4,  32'h0, "rst_mask");
      rd(BASE + 8,  32'h0, "rst_div");
`ifdef LED_PWM_EN
      rd(BASE + 12, 32'h0000_000F, "rst_duty");
`else
      rd(BASE + 12, 32'h0, "rst_duty");
`endif
      rst = 1'b1;
      tick();
      // DATA write: one-edge latency and truncating readback
      wr(4'h0, 32'hFFFF_A5C3);
      led_at(cyc,     32'h0,    "data_lat0");
      led_at(cyc + 1, 32'hA5C3, "data_lat1");
      rd(BASE, 32'h0000_A5C3, "data_rb");
      // write outside the window is ignored and reads back zero
      wr_abs(32'hFFFF_F070, 32'h0000_1234);
      led_at(cyc + 1, 32'hA5C3, "unsel_led");
      rd(BASE, 32'h0000_A5C3, "unsel_data");
      rd(32'hFFFF_F070, 32'h0, "unsel_rd");
`ifndef LED_PWM_EN
      wr(4'hC, 32'h0);
      led_at(cyc + 1, 32'hA5C3, "duty_ign_led");
      rd(BASE + 12, 32'h0, "duty_ign_rd");
`endif
      // blinking with DIV = 3
      wr(4'h0, 32'h0000_FFFF);
      wr(4'h4, 32'h0000_00FF);
      wr(4'h8, 32'd3);
      e = cyc;
      for (int k = 1; k <= 10; k++)
         led_at(e + k, (((k - 1) / 3) % 2) != 0 ? 32'hFF00 : 32'hFFFF, "blink3");
      wait_to(e + 10);
      wr(4'h8, 32'd0);
      led_at(e + 11, 32'hFF00, "div0_last");
      for (int k = 12; k <= 16; k++) led_at(e + k, 32'hFFFF, "div0_steady");
      wait_to(e + 16);
      // DIV rewrite while dark restarts in the lit phase
      wr(4'h8, 32'd2);
      a = cyc;
      led_at(a + 1, 32'hFFFF, "div2_a");
      led_at(a + 2, 32'hFFFF, "div2_b");
      led_at(a + 3, 32'hFF00, "div2_dark");
      for (int k = 4; k <= 8; k++) led_at(a + k, 32'hFFFF, "restart_lit");
      led_at(a + 9, 32'hFF00, "restart_toggle");
      tick();
      tick();
      wr(4'h8, 32'd5);
      rd(BASE + 8, 32'd5,   "div_rb");
      rd(BASE + 4, 32'h00FF, "mask_rb");
      // asynchronous reset between edges while blinking
      wait_to(a + 10);
      #1;
      rst = 1'b0;
      led_at(cyc, 32'h0, "async_rst_now");
      tick();
      led_at(cyc, 32'h0, "async_rst_held");
      rst = 1'b1;
      rd(BASE + 8, 32'h0, "post_rst_div");
      rd(BASE,     32'h0, "post_rst_data");
      rd(BASE + 4, 32'h0, "post_rst_mask");
      for (int k = 1; k <= 4; k++) led_at(cyc + k, 32'h0, "post_rst_led");
      wait_to(cyc + 4);
`ifdef LED_PWM_EN
      wr(4'h0, 32'h1);
      wr(4'hC, 32'd4);
      tick();
      pwm_window(4, "pwm_duty4");
      wr(4'hC, 32'd0);
      tick();
      pwm_window(0, "pwm_duty0");
      wr(4'hC, 32'd15);
      tick();
      pwm_window(16, "pwm_duty15");
`endif
      t = 0;
      while (q.size() != 0 && t < 50) begin
         tick();
         t++;
      end
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d checks never reached", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
